pipe_ctrl_unit: RTL and testbench

Registered successor to the combinational opcode decoder for the 5-stage MIPS pipeline. It decodes the ID-stage opcode into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB control registers. It also contains the load-use hazard stall counter, branch/jump flush generation and memory-stall freeze. It sits between the ID stage, the datapath pipeline registers, the PC and the data-cache stall line.

---
 rtl/pipe_ctrl_unit.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------------------------
// pipe_ctrl_unit
//
// Registered control unit for a 5-stage MIPS pipeline. Decodes the ID-stage opcode into a
// control word, carries it through the ID/EX, EX/MEM and MEM/WB control registers, and
// generates the front-end controls: load-use stall, branch/jump flush and memory-stall freeze.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   id_valid     IF/ID holds a real instruction
//   id_opcode    inst[31:26] in ID
//   id_rs        inst[25:21] in ID
//   id_rt        inst[20:16] in ID
//   branch_eq    ID comparator result (rs == rt)
//   mem_stall    data cache busy; freezes the whole pipeline
//   pc_write     PC load enable
//   ifid_write   IF/ID load enable
//   if_flush     zero IF/ID on the next edge
//   pc_src       00 PC+4, 01 branch target, 10 jump target
//   ex_reg_dst   EX: write rd (1) / rt (0)
//   ex_alu_src   EX: immediate operand
//   ex_alu_op    EX: 00 add, 01 sub, 10 funct-decoded
//   ex_rt        rt held in ID/EX (for the forwarding unit)
//   mem_read     MEM-stage load
//   mem_write    MEM-stage store
//   wb_reg_write WB-stage register write
//   wb_memto_reg WB: select memory data
//   illegal_op   pulse: unknown opcode decoded in ID
// ---------------------------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned ALUOP_W      = 2,
    // Bubbles per load-use hazard (1..3); CNT_W must be able to hold this value.
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned CNT_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [5:0]         id_opcode,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               branch_eq,
    input  logic               mem_stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               if_flush,
    output logic [1:0]         pc_src,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [REG_AW-1:0]  ex_rt,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_memto_reg,
    output logic               illegal_op
);

    // Opcodes understood by the decoder.
    localparam logic [5:0] OpRtype = 6'd0;
    localparam logic [5:0] OpJ     = 6'd2;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpAddi  = 6'd8;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;

    // ALU-op encodings sent to ALU control.
    localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(2);

    // PC source select.
    localparam logic [1:0] PcSeq    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    // ------------------------------------------------------------------
    // ID-stage decode
    // ------------------------------------------------------------------
    logic               dec_reg_dst;
    logic               dec_alu_src;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_mem_read;
    logic               dec_mem_write;
    logic               dec_reg_write;
    logic               dec_memto_reg;
    logic               dec_branch;
    logic               dec_jump;
    logic               dec_legal;
    // Instruction reads rt as a source register (load-use compare on rt applies).
    logic               dec_uses_rt;

    always_comb begin
        dec_reg_dst   = 1'b0;
        dec_alu_src   = 1'b0;
        dec_alu_op    = AluAdd;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_memto_reg = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_legal     = 1'b0;
        dec_uses_rt   = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OpRtype: begin
                    dec_legal     = 1'b1;
                    dec_uses_rt   = 1'b1;
                    dec_reg_dst   = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_alu_op    = AluFunct;
                end
                OpLw: begin
                    dec_legal     = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_mem_read  = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_memto_reg = 1'b1;
                    dec_alu_op    = AluAdd;
                end
                OpSw: begin
                    dec_legal     = 1'b1;
                    dec_uses_rt   = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_mem_write = 1'b1;
                    dec_alu_op    = AluAdd;
                end
                OpBeq: begin
                    dec_legal     = 1'b1;
                    dec_uses_rt   = 1'b1;
                    dec_branch    = 1'b1;
                    dec_alu_op    = AluSub;
                end
                OpAddi: begin
                    dec_legal     = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_alu_op    = AluAdd;
                end
                OpJ: begin
                    dec_legal     = 1'b1;
                    dec_jump      = 1'b1;
                end
                default: begin
                    dec_legal     = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic               idex_reg_dst_q,  idex_reg_dst_d;
    logic               idex_alu_src_q,  idex_alu_src_d;
    logic [ALUOP_W-1:0] idex_alu_op_q,   idex_alu_op_d;
    logic               idex_mem_read_q, idex_mem_read_d;
    logic               idex_mem_write_q, idex_mem_write_d;
    logic               idex_reg_write_q, idex_reg_write_d;
    logic               idex_memto_reg_q, idex_memto_reg_d;
    logic [REG_AW-1:0]  idex_rt_q,       idex_rt_d;

    logic               exmem_mem_read_q;
    logic               exmem_mem_write_q;
    logic               exmem_reg_write_q;
    logic               exmem_memto_reg_q;

    logic               memwb_reg_write_q;
    logic               memwb_memto_reg_q;

    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
    logic lu_detect;
    logic lu_stall;

    always_comb begin
        lu_detect = 1'b0;
        if (idex_mem_read_q && (idex_rt_q != '0) && id_valid) begin
            lu_detect = (idex_rt_q == id_rs) || (dec_uses_rt && (idex_rt_q == id_rt));
        end
        // The detect cycle is itself the first bubble; the counter covers the rest.
        lu_stall = (cnt_q != '0) || lu_detect;
    end

    always_comb begin
        cnt_d = '0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (lu_detect) begin
            cnt_d = CNT_W'(LU_STALL_CYC - 1);
        end
    end

    // ID/EX next value: a stall injects an all-zero bubble.
    always_comb begin
        idex_reg_dst_d   = 1'b0;
        idex_alu_src_d   = 1'b0;
        idex_alu_op_d    = AluAdd;
        idex_mem_read_d  = 1'b0;
        idex_mem_write_d = 1'b0;
        idex_reg_write_d = 1'b0;
        idex_memto_reg_d = 1'b0;
        idex_rt_d        = '0;
        if (!lu_stall) begin
            idex_reg_dst_d   = dec_reg_dst;
            idex_alu_src_d   = dec_alu_src;
            idex_alu_op_d    = dec_alu_op;
            idex_mem_read_d  = dec_mem_read;
            idex_mem_write_d = dec_mem_write;
            idex_reg_write_d = dec_reg_write;
            idex_memto_reg_d = dec_memto_reg;
            // Invalid and unknown instructions enter as a clean bubble, rt included.
            idex_rt_d        = dec_legal ? id_rt : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_reg_dst_q    <= 1'b0;
            idex_alu_src_q    <= 1'b0;
            idex_alu_op_q     <= AluAdd;
            idex_mem_read_q   <= 1'b0;
            idex_mem_write_q  <= 1'b0;
            idex_reg_write_q  <= 1'b0;
            idex_memto_reg_q  <= 1'b0;
            idex_rt_q         <= '0;
            exmem_mem_read_q  <= 1'b0;
            exmem_mem_write_q <= 1'b0;
            exmem_reg_write_q <= 1'b0;
            exmem_memto_reg_q <= 1'b0;
            memwb_reg_write_q <= 1'b0;
            memwb_memto_reg_q <= 1'b0;
            cnt_q             <= '0;
        end else if (!mem_stall) begin
            idex_reg_dst_q    <= idex_reg_dst_d;
            idex_alu_src_q    <= idex_alu_src_d;
            idex_alu_op_q     <= idex_alu_op_d;
            idex_mem_read_q   <= idex_mem_read_d;
            idex_mem_write_q  <= idex_mem_write_d;
            idex_reg_write_q  <= idex_reg_write_d;
            idex_memto_reg_q  <= idex_memto_reg_d;
            idex_rt_q         <= idex_rt_d;
            exmem_mem_read_q  <= idex_mem_read_q;
            exmem_mem_write_q <= idex_mem_write_q;
            exmem_reg_write_q <= idex_reg_write_q;
            exmem_memto_reg_q <= idex_memto_reg_q;
            memwb_reg_write_q <= exmem_reg_write_q;
            memwb_memto_reg_q <= exmem_memto_reg_q;
            cnt_q             <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Front-end controls: reset > mem_stall > load-use > branch/jump
    // ------------------------------------------------------------------
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        if_flush   = 1'b0;
        pc_src     = PcSeq;
        illegal_op = 1'b0;
        if (!rst && !mem_stall && !lu_stall) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            // Only raised once the instruction actually leaves ID, so it pulses once.
            illegal_op = id_valid && !dec_legal;
            if (dec_jump) begin
                pc_src   = PcJump;
                if_flush = 1'b1;
            end else if (dec_branch && branch_eq) begin
                pc_src   = PcBranch;
                if_flush = 1'b1;
            end
        end
    end

    assign ex_reg_dst   = idex_reg_dst_q;
    assign ex_alu_src   = idex_alu_src_q;
    assign ex_alu_op    = idex_alu_op_q;
    assign ex_rt        = idex_rt_q;
    assign mem_read     = exmem_mem_read_q;
    assign mem_write    = exmem_mem_write_q;
    assign wb_reg_write = memwb_reg_write_q;
    assign wb_memto_reg = memwb_memto_reg_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//
// Directed scenarios for each feature, then a randomized run checked against a behavioural
// pipeline model (a three-entry array of control words plus a remaining-bubble count).
// ---------------------------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam int unsigned LU = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       branch_eq;
    logic       mem_stall;
    logic       pc_write;
    logic       ifid_write;
    logic       if_flush;
    logic [1:0] pc_src;
    logic       ex_reg_dst;
    logic       ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rt;
    logic       mem_read;
    logic       mem_write;
    logic       wb_reg_write;
    logic       wb_memto_reg;
    logic       illegal_op;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .REG_AW      (5),
        .ALUOP_W     (2),
        .LU_STALL_CYC(LU),
        .CNT_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .branch_eq   (branch_eq),
        .mem_stall   (mem_stall),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .if_flush    (if_flush),
        .pc_src      (pc_src),
        .ex_reg_dst  (ex_reg_dst),
        .ex_alu_src  (ex_alu_src),
        .ex_alu_op   (ex_alu_op),
        .ex_rt       (ex_rt),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .wb_reg_write(wb_reg_write),
        .wb_memto_reg(wb_memto_reg),
        .illegal_op  (illegal_op)
    );

    // front = {pc_write, ifid_write, if_flush, pc_src, illegal_op}
    // stg   = {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, mem_read, mem_write,
    //          wb_reg_write, wb_memto_reg}
    logic [5:0]  front;
    logic [12:0] stg;
    assign front = {pc_write, ifid_write, if_flush, pc_src, illegal_op};
    assign stg   = {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, mem_read, mem_write,
                    wb_reg_write, wb_memto_reg};

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [4:0] rt;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       memto_reg;
        logic       branch;
        logic       jump;
    } word_t;

    word_t pipe [3];   // [0] ID/EX, [1] EX/MEM, [2] MEM/WB
    int    bub_left;   // bubbles still owed after the current cycle

    function automatic bit is_legal(input bit [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd8 ||
               op == 6'd2;
    endfunction

    function automatic bit reads_rt(input bit [5:0] op);
        return op == 6'd0 || op == 6'd43 || op == 6'd4;
    endfunction

    function automatic word_t spec_decode(input bit v, input bit [5:0] op, input bit [4:0] rt);
        word_t w;
        w = '0;
        if (!v || !is_legal(op)) return w;
        case (op)
            6'd0:  begin w.reg_dst = 1; w.reg_write = 1; w.alu_op = 2'b10; end
            6'd35: begin w.alu_src = 1; w.mem_read = 1; w.reg_write = 1; w.memto_reg = 1; end
            6'd43: begin w.alu_src = 1; w.mem_write = 1; end
            6'd4:  begin w.branch = 1; w.alu_op = 2'b01; end
            6'd8:  begin w.alu_src = 1; w.reg_write = 1; end
            default: w.jump = 1;
        endcase
        w.rt = rt;
        return w;
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic drive(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                         input bit beq, input bit ms);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        branch_eq = beq;
        mem_stall = ms;
        #1;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            cyc();
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        rst = 1'b1;
        drive(1, 6'h3F, 1, 2, 1, 0);
        vectors++;
        if (front !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_front: got %b want %b", front, 6'b000000);
        end
        cyc();
        drive(1, 6'd2, 1, 2, 1, 0);
        cyc();
        vectors++;
        if (stg !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_stages: got %b want %b", stg, 13'd0);
        end
        vectors++;
        if (front !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_held_front: got %b want %b", front, 6'b000000);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL first_after_reset: got %b want %b", front, 6'b110000);
        end
        cyc();
    endtask

    task automatic test_rtype;
        idle_cycles(3);
        drive(1, 6'd0, 1, 2, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL rtype_front: got %b want %b", front, 6'b110000);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (stg[12:4] !== 9'b1_0_10_00010) begin
            miscompares++;
            $display("FAIL rtype_ex: got %b want %b", stg[12:4], 9'b1_0_10_00010);
        end
        cyc();
        vectors++;
        if (stg[3:2] !== 2'b00) begin
            miscompares++;
            $display("FAIL rtype_mem: got %b want %b", stg[3:2], 2'b00);
        end
        cyc();
        vectors++;
        if (stg[1:0] !== 2'b10) begin
            miscompares++;
            $display("FAIL rtype_wb: got %b want %b", stg[1:0], 2'b10);
        end
    endtask

    task automatic test_load_use;
        int stalls;
        bit issued;
        stalls = 0;
        issued = 0;
        idle_cycles(3);
        drive(1, 6'd35, 0, 5, 0, 0);
        cyc();
        for (int i = 0; i < 6; i++) begin
            if (!issued) drive(1, 6'd0, 5, 7, 0, 0);
            else drive(0, 0, 0, 0, 0, 0);
            if (!issued) begin
                if (pc_write === 1'b0 && ifid_write === 1'b0) stalls++;
                else issued = 1;
                if (i > 0 && !issued) begin
                    vectors++;
                    if (stg[12:4] !== 9'd0) begin
                        miscompares++;
                        $display("FAIL load_use_bubble: got %b want %b", stg[12:4], 9'd0);
                    end
                end
            end
            cyc();
        end
        vectors++;
        if (stalls != LU) begin
            miscompares++;
            $display("FAIL load_use_stall_count: got %0d want %0d", stalls, LU);
        end
        // Load to $zero never stalls.
        idle_cycles(3);
        drive(1, 6'd35, 0, 0, 0, 0);
        cyc();
        drive(1, 6'd0, 0, 0, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL load_use_rt0: got %b want %b", front, 6'b110000);
        end
        cyc();
        // addi does not read rt, so an rt-only match is not a hazard.
        idle_cycles(3);
        drive(1, 6'd35, 0, 6, 0, 0);
        cyc();
        drive(1, 6'd8, 1, 6, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL load_use_addi_rt: got %b want %b", front, 6'b110000);
        end
        cyc();
    endtask

    task automatic test_branch;
        idle_cycles(3);
        drive(1, 6'd4, 1, 2, 1, 0);
        vectors++;
        if (front !== 6'b111010) begin
            miscompares++;
            $display("FAIL beq_taken: got %b want %b", front, 6'b111010);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL beq_flush_once: got %b want %b", front, 6'b110000);
        end
        vectors++;
        if (stg[12:4] !== 9'b0_0_01_00010) begin
            miscompares++;
            $display("FAIL beq_ex: got %b want %b", stg[12:4], 9'b0_0_01_00010);
        end
        drive(1, 6'd4, 1, 2, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL beq_not_taken: got %b want %b", front, 6'b110000);
        end
        cyc();
        drive(1, 6'd2, 3, 4, 0, 0);
        vectors++;
        if (front !== 6'b111100) begin
            miscompares++;
            $display("FAIL jump: got %b want %b", front, 6'b111100);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL jump_flush_once: got %b want %b", front, 6'b110000);
        end
        // A taken branch waiting behind a load-use stall is only acted on afterwards.
        idle_cycles(3);
        drive(1, 6'd35, 0, 3, 0, 0);
        cyc();
        for (int i = 0; i < LU; i++) begin
            drive(1, 6'd4, 3, 0, 1, 0);
            vectors++;
            if (front !== 6'b000000) begin
                miscompares++;
                $display("FAIL beq_during_stall: got %b want %b", front, 6'b000000);
            end
            cyc();
        end
        drive(1, 6'd4, 3, 0, 1, 0);
        vectors++;
        if (front !== 6'b111010) begin
            miscompares++;
            $display("FAIL beq_after_stall: got %b want %b", front, 6'b111010);
        end
        cyc();
    endtask

    task automatic test_mem_stall;
        idle_cycles(3);
        drive(1, 6'd35, 0, 9, 0, 0);
        cyc();
        drive(1, 6'd0, 9, 4, 0, 0);
        vectors++;
        if (front !== 6'b000000) begin
            miscompares++;
            $display("FAIL ms_detect: got %b want %b", front, 6'b000000);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, 6'd0, 9, 4, 0, 1);
            vectors++;
            if (front !== 6'b000000) begin
                miscompares++;
                $display("FAIL ms_freeze_front: got %b want %b", front, 6'b000000);
            end
            vectors++;
            if (stg !== 13'b0_0_00_00000_1_0_0_0) begin
                miscompares++;
                $display("FAIL ms_freeze_stages: got %b want %b", stg, 13'b0_0_00_00000_1_0_0_0);
            end
            cyc();
        end
        drive(1, 6'd0, 9, 4, 0, 0);
        vectors++;
        if (front !== 6'b000000) begin
            miscompares++;
            $display("FAIL ms_resume_bubble: got %b want %b", front, 6'b000000);
        end
        cyc();
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL ms_add_issues: got %b want %b", front, 6'b110000);
        end
        vectors++;
        if (stg !== 13'b0_0_00_00000_0_0_1_1) begin
            miscompares++;
            $display("FAIL ms_lw_in_wb: got %b want %b", stg, 13'b0_0_00_00000_0_0_1_1);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (stg[12:4] !== 9'b1_0_10_00100) begin
            miscompares++;
            $display("FAIL ms_add_in_ex: got %b want %b", stg[12:4], 9'b1_0_10_00100);
        end
    endtask

    task automatic test_illegal;
        idle_cycles(3);
        drive(1, 6'h3F, 1, 2, 0, 0);
        vectors++;
        if (front !== 6'b110001) begin
            miscompares++;
            $display("FAIL illegal_pulse: got %b want %b", front, 6'b110001);
        end
        cyc();
        drive(0, 6'h3F, 0, 0, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL illegal_invalid_or_drop: got %b want %b", front, 6'b110000);
        end
        vectors++;
        if (stg[12:4] !== 9'd0) begin
            miscompares++;
            $display("FAIL illegal_bubble_ex: got %b want %b", stg[12:4], 9'd0);
        end
        cyc();
        cyc();
        vectors++;
        if (stg !== 13'd0) begin
            miscompares++;
            $display("FAIL illegal_bubble_wb: got %b want %b", stg, 13'd0);
        end
    endtask

    task automatic test_reset_mid_stall;
        idle_cycles(3);
        drive(1, 6'd35, 0, 10, 0, 0);
        cyc();
        drive(1, 6'd0, 10, 7, 0, 0);
        cyc();
        rst = 1'b1;
        drive(1, 6'd0, 10, 7, 0, 0);
        vectors++;
        if (front !== 6'b000000) begin
            miscompares++;
            $display("FAIL rst_stall_front: got %b want %b", front, 6'b000000);
        end
        cyc();
        vectors++;
        if (stg !== 13'd0) begin
            miscompares++;
            $display("FAIL rst_clears_stages: got %b want %b", stg, 13'd0);
        end
        rst = 1'b0;
        drive(1, 6'd0, 10, 7, 0, 0);
        vectors++;
        if (front !== 6'b110000) begin
            miscompares++;
            $display("FAIL rst_no_residual: got %b want %b", front, 6'b110000);
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (stg[12:4] !== 9'b1_0_10_00111) begin
            miscompares++;
            $display("FAIL rst_add_in_ex: got %b want %b", stg[12:4], 9'b1_0_10_00111);
        end
        cyc();
    endtask

    task automatic test_random;
        bit [5:0]  ops [6];
        bit        r_rst, ms, v, beq, haz, stall;
        bit [5:0]  op;
        bit [4:0]  rs, rt;
        word_t     dw;
        bit [5:0]  exp_front;
        bit [12:0] exp_stg;
        bit [1:0]  src;
        bit        flush;
        int        idx;
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        bub_left = 0;
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            ms    = ($urandom_range(0, 6) == 0);
            v     = ($urandom_range(0, 9) != 0);
            idx   = $urandom_range(0, 7);
            if (idx >= 6) op = 6'($urandom_range(0, 63));
            else op = ops[idx];
            if ($urandom_range(0, 3) == 0) op = 6'd35;
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            beq = 1'($urandom_range(0, 1));
            if (!v) begin
                op = 0;
                rs = 0;
                rt = 0;
            end
            rst = r_rst;
            drive(v, op, rs, rt, beq, ms);

            haz = pipe[0].mem_read && pipe[0].rt != 0 && v &&
                  (pipe[0].rt == rs || (reads_rt(op) && pipe[0].rt == rt));
            stall = (bub_left > 0) || haz;
            dw    = spec_decode(v, op, rt);
            flush = dw.jump || (dw.branch && beq);
            src   = dw.jump ? 2'b10 : ((dw.branch && beq) ? 2'b01 : 2'b00);
            if (r_rst || ms || stall) exp_front = 6'b000000;
            else exp_front = {1'b1, 1'b1, flush, src, v && !is_legal(op)};
            exp_stg = {pipe[0].reg_dst, pipe[0].alu_src, pipe[0].alu_op, pipe[0].rt,
                       pipe[1].mem_read, pipe[1].mem_write, pipe[2].reg_write,
                       pipe[2].memto_reg};

            vectors++;
            if (front !== exp_front) begin
                miscompares++;
                $display("FAIL rand_front[%0d]: got %b want %b", n, front, exp_front);
            end
            vectors++;
            if (stg !== exp_stg) begin
                miscompares++;
                $display("FAIL rand_stages[%0d]: got %b want %b", n, stg, exp_stg);
            end

            if (r_rst) begin
                for (int k = 0; k < 3; k++) pipe[k] = '0;
                bub_left = 0;
            end else if (!ms) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = stall ? '0 : dw;
                if (bub_left > 0) bub_left--;
                else if (haz) bub_left = LU - 1;
            end
            cyc();
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_rtype();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
